ncount: RTL and testbench

NCOUNT -- requirements
Module: ncount

---
 rtl/ncount_pkg.sv | 13 +
 rtl/ncount_ctr.sv | 20 ++
 rtl/ncount.sv | 116 +++++++++++
 tb/tb_ncount.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ncount_pkg.sv
// Shared state encoding and counting-mode constants for the ncount event counter.
package ncount_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      SAT  = 2'b10
   } state_t;

   localparam int MODE_CONSEC = 0;
   localparam int MODE_CUMUL  = 1;

endpackage

// File: rtl/ncount_ctr.sv
// Wrapping event counter: adds one on each cycle that inc is high.
// Latency: count reflects inc one edge later; no backpressure.
module ncount_ctr #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ncount.sv
// Threshold event counter with consecutive/cumulative modes, wrap or saturate.
// Latency: all outputs registered, one edge after the sampled x; no backpressure.
module ncount
   import ncount_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int THRESH = 2,
   parameter int MODE   = 0,
   parameter int WRAP   = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             x,
   output logic [WIDTH-1:0] out,
   output logic             z,
   output logic [1:0]       state,
   output logic [WIDTH-1:0] hits
);

   if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
      $error("ncount: WIDTH out of range");
   end
   if (THRESH < 1 || THRESH > (2**WIDTH) - 1) begin : g_bad_thresh
      $error("ncount: THRESH out of range");
   end
   if (MODE != MODE_CONSEC && MODE != MODE_CUMUL) begin : g_bad_mode
      $error("ncount: MODE must be 0 or 1");
   end
   if (WRAP != 0 && WRAP != 1) begin : g_bad_wrap
      $error("ncount: WRAP must be 0 or 1");
   end

   localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

   state_t           st_q, st_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             z_q, z_d;
   logic             hit;
   logic [WIDTH:0]   cnt_inc;

   assign cnt_inc = {1'b0, cnt_q} + (WIDTH+1)'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q  <= IDLE;
         cnt_q <= '0;
         z_q   <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         z_q   <= z_d;
      end
   end

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      z_d   = 1'b0;
      hit   = 1'b0;
      if (clr) begin
         st_d  = IDLE;
         cnt_d = '0;
      end else begin
         case (st_q)
            IDLE, RUN: begin
               if (en) begin
                  if (x) begin
                     if (cnt_inc == (WIDTH+1)'(THRESH)) begin
                        z_d = 1'b1;
                        hit = 1'b1;
                        if (WRAP == 1) begin
                           st_d  = IDLE;
                           cnt_d = '0;
                        end else begin
                           st_d  = SAT;
                           cnt_d = THR;
                        end
                     end else begin
                        st_d  = RUN;
                        cnt_d = cnt_inc[WIDTH-1:0];
                     end
                  end else if (MODE == MODE_CONSEC) begin
                     st_d  = IDLE;
                     cnt_d = '0;
                  end
               end
            end
            SAT: begin
               // Saturated: x=1 holds silently; only a consecutive-mode gap leaves.
               if (en && !x && MODE == MODE_CONSEC) begin
                  st_d  = IDLE;
                  cnt_d = '0;
               end
            end
            default: begin
               st_d  = IDLE;
               cnt_d = '0;
            end
         endcase
      end
   end

   ncount_ctr #(.WIDTH(WIDTH)) u_hits (
      .clock (clock),
      .reset (reset),
      .inc   (hit),
      .count (hits)
   );

   assign out   = cnt_q;
   assign z     = z_q;
   assign state = st_q;

endmodule

// File: tb/tb_ncount.sv
// Directed table-driven bench for ncount across four parameter sets.
module tb_ncount;

   logic clock;
   logic reset;
   logic en_i  [4];
   logic clr_i [4];
   logic x_i   [4];
   logic [3:0] o_a [4];
   logic [3:0] h_a [4];
   logic       z_a [4];
   logic [1:0] s_a [4];
   logic [1:0] out3, hits3;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int         inst;
      logic       en;
      logic       clr;
      logic       x;
      logic [3:0] o;
      logic       zz;
      logic [1:0] st;
      logic [3:0] h;
   } vec_t;

   vec_t vq[$];

   initial clock = 1'b0;
   always #20 clock = ~clock;

   ncount u0 (.clock(clock), .reset(reset), .en(en_i[0]), .clr(clr_i[0]), .x(x_i[0]),
              .out(o_a[0]), .z(z_a[0]), .state(s_a[0]), .hits(h_a[0]));
   ncount #(.MODE(1), .THRESH(3)) u1 (.clock(clock), .reset(reset), .en(en_i[1]), .clr(clr_i[1]),
              .x(x_i[1]), .out(o_a[1]), .z(z_a[1]), .state(s_a[1]), .hits(h_a[1]));
   ncount #(.WRAP(0), .THRESH(2)) u2 (.clock(clock), .reset(reset), .en(en_i[2]), .clr(clr_i[2]),
              .x(x_i[2]), .out(o_a[2]), .z(z_a[2]), .state(s_a[2]), .hits(h_a[2]));
   ncount #(.WIDTH(2), .THRESH(1)) u3 (.clock(clock), .reset(reset), .en(en_i[3]), .clr(clr_i[3]),
              .x(x_i[3]), .out(out3), .z(z_a[3]), .state(s_a[3]), .hits(hits3));

   assign o_a[3] = {2'b00, out3};
   assign h_a[3] = {2'b00, hits3};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_all(input string tag, input int k, input vec_t v);
      check({tag, " out"},   int'(o_a[k]), int'(v.o));
      check({tag, " z"},     int'(z_a[k]), int'(v.zz));
      check({tag, " state"}, int'(s_a[k]), int'(v.st));
      check({tag, " hits"},  int'(h_a[k]), int'(v.h));
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 4; k++) begin
         en_i[k] = 1'b0; clr_i[k] = 1'b0; x_i[k] = 1'b0;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      @(negedge clock);
      idle_inputs();
      en_i[v.inst]  = v.en;
      clr_i[v.inst] = v.clr;
      x_i[v.inst]   = v.x;
      @(posedge clock);
      #1;
      check_all($sformatf("v%0d/u%0d", idx, v.inst), v.inst, v);
   endtask

   initial begin
      vec_t zero;
      zero = '{0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 4'd0};

      // u1: cumulative, threshold 3
      vq.push_back('{1, 1, 0, 1, 4'd1, 0, 2'b01, 4'd0});
      vq.push_back('{1, 1, 0, 0, 4'd1, 0, 2'b01, 4'd0});
      vq.push_back('{1, 1, 0, 1, 4'd2, 0, 2'b01, 4'd0});
      vq.push_back('{1, 1, 0, 0, 4'd2, 0, 2'b01, 4'd0});
      vq.push_back('{1, 1, 0, 1, 4'd0, 1, 2'b00, 4'd1});
      // u2: saturating, threshold 2, consecutive
      vq.push_back('{2, 1, 0, 1, 4'd1, 0, 2'b01, 4'd0});
      vq.push_back('{2, 1, 0, 1, 4'd2, 1, 2'b10, 4'd1});
      vq.push_back('{2, 1, 0, 1, 4'd2, 0, 2'b10, 4'd1});
      vq.push_back('{2, 1, 0, 1, 4'd2, 0, 2'b10, 4'd1});
      vq.push_back('{2, 1, 0, 1, 4'd2, 0, 2'b10, 4'd1});
      vq.push_back('{2, 1, 0, 0, 4'd0, 0, 2'b00, 4'd1});
      // u3: 2-bit, threshold 1, hits wraps
      vq.push_back('{3, 1, 0, 1, 4'd0, 1, 2'b00, 4'd1});
      vq.push_back('{3, 1, 0, 1, 4'd0, 1, 2'b00, 4'd2});
      vq.push_back('{3, 1, 0, 1, 4'd0, 1, 2'b00, 4'd3});
      vq.push_back('{3, 1, 0, 1, 4'd0, 1, 2'b00, 4'd0});
      vq.push_back('{3, 1, 0, 1, 4'd0, 1, 2'b00, 4'd1});
      vq.push_back('{3, 0, 0, 1, 4'd0, 0, 2'b00, 4'd1});
      // u0: defaults, pattern 1,1,0,1,1 then enable/clear behaviour
      vq.push_back('{0, 1, 0, 1, 4'd1, 0, 2'b01, 4'd0});
      vq.push_back('{0, 1, 0, 1, 4'd0, 1, 2'b00, 4'd1});
      vq.push_back('{0, 1, 0, 0, 4'd0, 0, 2'b00, 4'd1});
      vq.push_back('{0, 1, 0, 1, 4'd1, 0, 2'b01, 4'd1});
      vq.push_back('{0, 1, 0, 1, 4'd0, 1, 2'b00, 4'd2});
      vq.push_back('{0, 1, 0, 1, 4'd1, 0, 2'b01, 4'd2});
      vq.push_back('{0, 0, 0, 1, 4'd1, 0, 2'b01, 4'd2});
      vq.push_back('{0, 0, 0, 1, 4'd1, 0, 2'b01, 4'd2});
      vq.push_back('{0, 0, 0, 1, 4'd1, 0, 2'b01, 4'd2});
      vq.push_back('{0, 0, 1, 1, 4'd0, 0, 2'b00, 4'd2});
      vq.push_back('{0, 1, 0, 1, 4'd1, 0, 2'b01, 4'd2});

      idle_inputs();
      reset = 1'b0;
      #30;
      for (int k = 0; k < 4; k++) check_all($sformatf("in_reset/u%0d", k), k, zero);
      #20;
      reset = 1'b1;
      @(posedge clock);
      #1;
      for (int k = 0; k < 4; k++) check_all($sformatf("post_reset/u%0d", k), k, zero);

      for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

      // Asynchronous reset mid-count on u0 (out=1, hits=2), between edges
      @(posedge clock);
      #10;
      reset = 1'b0;
      #1;
      check_all("async_reset/u0", 0, zero);
      check("async_reset/u3 hits", int'(h_a[3]), 0);
      @(negedge clock);
      en_i[0] = 1'b1; x_i[0] = 1'b1;
      @(posedge clock);
      #1;
      check_all("held_reset/u0", 0, zero);
      @(negedge clock);
      idle_inputs();
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("after_release en0 out", int'(o_a[0]), 0);
      @(negedge clock);
      en_i[0] = 1'b1; x_i[0] = 1'b1;
      @(posedge clock);
      #1;
      check("first_count out", int'(o_a[0]), 1);
      check("first_count z", int'(z_a[0]), 0);
      check("first_count state", int'(s_a[0]), 1);
      @(negedge clock);
      idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
